// File: rtl/fx_arb.sv
// Two-master arbiter onto the fx register bus: one transaction at a time,
// round-robin or fixed priority, with every output driven from a register.
module fx_arb #(
    parameter int RR_EN = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m0_wdata,
    input  logic [7:0]  m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [7:0]  m0_rdata,
    output logic [7:0]  m1_rdata,
    output logic        fx_wr,
    output logic        fx_rd,
    output logic [15:0] fx_waddr,
    output logic [15:0] fx_raddr,
    output logic [7:0]  fx_data,
    input  logic [7:0]  fx_q,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic        gnt, gnt_nx;
    logic        last_gnt, last_gnt_nx;
    logic        pick;
    logic        we_l, we_nx;
    logic [15:0] addr_l, addr_nx;
    logic [7:0]  wdata_l, wdata_nx;
    logic        m0_ack_nx, m1_ack_nx;
    logic [7:0]  m0_rdata_nx, m1_rdata_nx;
    logic        fx_wr_nx, fx_rd_nx;
    logic [15:0] fx_waddr_nx, fx_raddr_nx;
    logic [7:0]  fx_data_nx;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            we_l     <= 1'b0;
            addr_l   <= '0;
            wdata_l  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            fx_wr    <= 1'b0;
            fx_rd    <= 1'b0;
            fx_waddr <= '0;
            fx_raddr <= '0;
            fx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last_gnt <= last_gnt_nx;
            we_l     <= we_nx;
            addr_l   <= addr_nx;
            wdata_l  <= wdata_nx;
            m0_ack   <= m0_ack_nx;
            m1_ack   <= m1_ack_nx;
            m0_rdata <= m0_rdata_nx;
            m1_rdata <= m1_rdata_nx;
            fx_wr    <= fx_wr_nx;
            fx_rd    <= fx_rd_nx;
            fx_waddr <= fx_waddr_nx;
            fx_raddr <= fx_raddr_nx;
            fx_data  <= fx_data_nx;
            busy     <= (state_nx != IDLE);
        end
    end

    // Outputs are computed one state ahead so they can be registered.
    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        last_gnt_nx = last_gnt;
        pick        = 1'b0;
        we_nx       = we_l;
        addr_nx     = addr_l;
        wdata_nx    = wdata_l;
        m0_ack_nx   = 1'b0;
        m1_ack_nx   = 1'b0;
        m0_rdata_nx = m0_rdata;
        m1_rdata_nx = m1_rdata;
        fx_wr_nx    = 1'b0;
        fx_rd_nx    = 1'b0;
        fx_waddr_nx = '0;
        fx_raddr_nx = '0;
        fx_data_nx  = '0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On contention round-robin favours whoever was not granted last.
                    if (m0_req && m1_req) pick = (RR_EN != 0) ? ~last_gnt : 1'b0;
                    else                  pick = m1_req;
                    gnt_nx      = pick;
                    last_gnt_nx = pick;
                    we_nx       = pick ? m1_we    : m0_we;
                    addr_nx     = pick ? m1_addr  : m0_addr;
                    wdata_nx    = pick ? m1_wdata : m0_wdata;
                    fx_wr_nx    = we_nx;
                    fx_rd_nx    = ~we_nx;
                    if (we_nx) begin
                        fx_waddr_nx = addr_nx;
                        fx_data_nx  = wdata_nx;
                    end else begin
                        fx_raddr_nx = addr_nx;
                    end
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (we_l) begin
                    state_nx  = DONE;
                    m0_ack_nx = ~gnt;
                    m1_ack_nx = gnt;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                state_nx  = DONE;
                m0_ack_nx = ~gnt;
                m1_ack_nx = gnt;
                if (gnt) m1_rdata_nx = fx_q;
                else     m0_rdata_nx = fx_q;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fx_arb.sv
// Bench for fx_arb: timing model of arbitration feeds an expected queue that a
// negedge monitor drains; a second instance exercises fixed priority.
module tb_fx_arb;

    localparam int MAXT = 8;

    typedef struct {
        int          gap;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          strobe;
    } stim_t;

    typedef struct {
        int          m;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
        int          strobe;
        int          ack;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  ack;
    logic [15:0] addr [2];
    logic [7:0]  wdata [2];
    logic [7:0]  m0_rdata, m1_rdata;
    logic        fx_wr, fx_rd, busy;
    logic [15:0] fx_waddr, fx_raddr;
    logic [7:0]  fx_data, fx_q;

    logic [1:0]  p_req, p_we, p_ack;
    logic [15:0] p_addr0, p_addr1, p_waddr, p_raddr;
    logic [7:0]  p_wdata0, p_wdata1, p_rdata0, p_rdata1, p_fx_data, p_fx_q;
    logic        p_fx_wr, p_fx_rd, p_busy;

    int          cyc = 0;
    int          checks;
    int          errors;
    logic        mon_en;

    stim_t       stim [2][MAXT];
    int          n [2];
    exp_t        exp_q[$];
    int          m_last;
    logic [7:0]  m_rdata [2];
    logic [7:0]  sl_mem [256];

    exp_t        h;
    logic [1:0]  exp_ack;
    logic        exp_busy;
    logic        rd_seen;
    logic [15:0] ra;

    fx_arb #(.RR_EN(1)) dut (
        .clk_sys(clk), .rst(rst),
        .m0_req(req[0]), .m1_req(req[1]), .m0_we(we[0]), .m1_we(we[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]), .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
        .m0_ack(ack[0]), .m1_ack(ack[1]), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .fx_wr(fx_wr), .fx_rd(fx_rd), .fx_waddr(fx_waddr), .fx_raddr(fx_raddr),
        .fx_data(fx_data), .fx_q(fx_q), .busy(busy)
    );

    fx_arb #(.RR_EN(0)) dut_fp (
        .clk_sys(clk), .rst(rst),
        .m0_req(p_req[0]), .m1_req(p_req[1]), .m0_we(p_we[0]), .m1_we(p_we[1]),
        .m0_addr(p_addr0), .m1_addr(p_addr1), .m0_wdata(p_wdata0), .m1_wdata(p_wdata1),
        .m0_ack(p_ack[0]), .m1_ack(p_ack[1]), .m0_rdata(p_rdata0), .m1_rdata(p_rdata1),
        .fx_wr(p_fx_wr), .fx_rd(p_fx_rd), .fx_waddr(p_waddr), .fx_raddr(p_raddr),
        .fx_data(p_fx_data), .fx_q(p_fx_q), .busy(p_busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // slave: returns its memory contents one cycle after a read strobe, noise otherwise
    initial begin
        fx_q = 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = fx_rd;
            ra      = fx_raddr;
            @(posedge clk);
            #1;
            fx_q = rd_seen ? sl_mem[ra[7:0]] : 8'($urandom);
        end
    end

    // reference model: each grant happens at the first cycle the arbiter is idle
    // and someone is requesting; strobe one cycle later, ack after 1 (wr) or 2 (rd) more.
    function automatic void add(input int m, input int gap, input logic w,
                                input logic [15:0] a, input logic [7:0] d);
        stim[m][n[m]] = '{gap, w, a, d, 0};
        n[m]++;
    endfunction

    function automatic void plan(input int start);
        int   idx [2];
        int   rdy [2];
        int   free_at;
        int   t;
        int   w;
        logic c0, c1;
        exp_t e;
        idx = '{0, 0};
        for (int m = 0; m < 2; m++) rdy[m] = (n[m] > 0) ? start + stim[m][0].gap : 0;
        free_at = start;
        while (idx[0] < n[0] || idx[1] < n[1]) begin
            c0 = idx[0] < n[0];
            c1 = idx[1] < n[1];
            t = 1 << 30;
            if (c0) t = rdy[0];
            if (c1 && rdy[1] < t) t = rdy[1];
            if (t < free_at) t = free_at;
            c0 = c0 && (rdy[0] <= t);
            c1 = c1 && (rdy[1] <= t);
            if (c0 && c1) w = 1 - m_last;
            else          w = c1 ? 1 : 0;
            m_last   = w;
            e.m      = w;
            e.we     = stim[w][idx[w]].we;
            e.addr   = stim[w][idx[w]].addr;
            e.wdata  = stim[w][idx[w]].wdata;
            e.strobe = t + 1;
            e.ack    = t + (e.we ? 2 : 3);
            if (!e.we) m_rdata[w] = sl_mem[e.addr[7:0]];
            e.rd0    = m_rdata[0];
            e.rd1    = m_rdata[1];
            stim[w][idx[w]].strobe = e.strobe;
            exp_q.push_back(e);
            free_at = e.ack + 1;
            idx[w]++;
            if (idx[w] < n[w]) rdy[w] = e.ack + 1 + stim[w][idx[w]].gap;
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && cyc == exp_q[0].strobe) begin
                h = exp_q[0];
                chk("strobe_kind", {fx_wr, fx_rd}, {h.we, ~h.we});
                if (h.we) chk("wr_bus", {fx_waddr, fx_data, fx_raddr}, {h.addr, h.wdata, 16'h0000});
                else      chk("rd_bus", {fx_raddr, fx_waddr, fx_data}, {h.addr, 16'h0000, 8'h00});
            end else begin
                chk("bus_quiet", {fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data}, 64'd0);
            end
            exp_ack  = 2'b00;
            exp_busy = 1'b0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                if (cyc == h.ack) exp_ack = (h.m == 1) ? 2'b10 : 2'b01;
                exp_busy = (cyc >= h.strobe) && (cyc <= h.ack);
            end
            chk("ack", ack, exp_ack);
            chk("busy", busy, exp_busy);
            if (exp_q.size() > 0 && cyc == exp_q[0].ack) begin
                chk("rdata", {m1_rdata, m0_rdata}, {exp_q[0].rd1, exp_q[0].rd0});
                void'(exp_q.pop_front());
            end
        end
    end

    // driver for one master: hold req until ack, scramble fields once granted
    task automatic drive(input int m);
        int budget;
        for (int k = 0; k < n[m]; k++) begin
            repeat (stim[m][k].gap) begin
                @(posedge clk);
                #1;
            end
            req[m]   = 1'b1;
            we[m]    = stim[m][k].we;
            addr[m]  = stim[m][k].addr;
            wdata[m] = stim[m][k].wdata;
            budget   = 0;
            do begin
                @(negedge clk);
                budget++;
                if (!ack[m] && cyc >= stim[m][k].strobe) begin
                    we[m]    = 1'($urandom);
                    addr[m]  = 16'($urandom);
                    wdata[m] = 8'($urandom);
                end
            end while (!ack[m] && budget < 400);
            if (!ack[m]) chk("ack_timeout", ack[m], 64'd1);
            @(posedge clk);
            #1;
            req[m]   = 1'b0;
            addr[m]  = 16'($urandom);
            wdata[m] = 8'($urandom);
        end
    endtask

    task automatic run_phase();
        int start;
        @(posedge clk);
        #1;
        start = cyc;
        plan(start);
        fork
            drive(0);
            drive(1);
        join
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        n = '{0, 0};
        @(posedge clk);
        #1;
    endtask

    task automatic fp_test();
        int order[$];
        int n0;
        int got;
        n0 = 0;
        @(posedge clk);
        #1;
        p_req = 2'b11;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            @(negedge clk);
            if (p_ack != 2'b00) begin
                got = p_ack[1] ? 1 : 0;
                order.push_back(got);
                chk("fp_done_state", {p_fx_wr, p_fx_rd, p_waddr, p_raddr, p_fx_data, p_rdata1, p_rdata0, p_busy},
                    64'd1);
                @(posedge clk);
                #1;
                if (got == 0) begin
                    n0++;
                    if (n0 == 4) p_req[0] = 1'b0;
                end else begin
                    p_req[1] = 1'b0;
                end
            end
        end
        p_req = 2'b00;
        chk("fp_count", 64'(order.size()), 64'd5);
        // fixed priority: m1 waits until m0 has finished all four of its requests
        for (int i = 0; i < order.size(); i++) chk("fp_order", 64'(order[i]), (i < 4) ? 64'd0 : 64'd1);
    endtask

    task automatic reset_case(input logic w);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req[0] = 1'b1; we[0] = w; addr[0] = 16'h0A33; wdata[0] = 8'hC3;
        @(posedge clk);
        #1;
        if (!w) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", busy, 64'd1);
        chk("pre_rst_strobe", {fx_wr, fx_rd}, w ? 64'd2 : 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_outputs", {ack, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, busy}, 64'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        req[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ack", {ack, busy}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_last    = 1;
        m_rdata   = '{8'h00, 8'h00};
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; mon_en = 1'b0;
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr = '{16'h0000, 16'h0000}; wdata = '{8'h00, 8'h00};
        p_req = 2'b00; p_we = 2'b11; p_addr0 = 16'h0100; p_addr1 = 16'h0200;
        p_wdata0 = 8'h11; p_wdata1 = 8'h22; p_fx_q = 8'h00;
        n = '{0, 0};
        for (int i = 0; i < 256; i++) sl_mem[i] = 8'($urandom);
        sl_mem[8'h80] = 8'hA5;
        m_last  = 1;
        m_rdata = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ack, m1_rdata, m0_rdata, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, busy}, 64'd0);
        chk("reset_state_fp", {p_ack, p_busy, p_fx_wr, p_fx_rd}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        fp_test();

        add(0, 0, 1'b1, 16'h0581, 8'h5A);
        run_phase();
        add(1, 0, 1'b0, 16'h0580, 8'h00);
        run_phase();
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 1'($urandom), 16'($urandom), 8'($urandom));
            add(1, 0, 1'($urandom), 16'($urandom), 8'($urandom));
        end
        run_phase();
        add(0, 0, 1'b0, 16'h0380, 8'h00);
        add(1, 2, 1'b1, 16'h0412, 8'h77);
        run_phase();
        for (int r = 0; r < 6; r++) begin
            for (int m = 0; m < 2; m++) begin
                int cnt;
                cnt = $urandom_range(0, 5);
                for (int k = 0; k < cnt; k++)
                    add(m, $urandom_range(0, 4), 1'($urandom), 16'($urandom), 8'($urandom));
            end
            run_phase();
        end

        reset_case(1'b0);
        add(0, 0, 1'b1, 16'h0101, 8'h3C);
        add(1, 0, 1'b1, 16'h0202, 8'hC3);
        run_phase();
        reset_case(1'b1);
        add(0, 0, 1'b0, 16'h0180, 8'h00);
        add(1, 0, 1'b0, 16'h0281, 8'h00);
        run_phase();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
